gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
- Self-checking response end for the N-input AND gate.
- Consumes (input vector, observed output) samples through a valid/ready handshake and compares each observed output against the expected AND of the input vector.
- Counts mismatches and tracks coverage of all 2**N input patterns.
- Raises done/pass once every pattern has been seen. This is the hardware counterpart of the exhaustive stimulus that drives the gate.

Parameters:
- N, 2, gate input width; coverage bitmap holds 2**N bits.
- CNT_W, 16, width of the sample and fail counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; clears all results and begins a session
- in_vec  input  N  input vector that was applied to the gate
- out_bit  input  1  observed gate output for in_vec
- valid  input  1  sample present on in_vec/out_bit
- ready  output  1  checker accepts samples
- busy  output  1  session in progress
- done  output  1  every pattern covered, or aborted (see Optional Feature)
- pass  output  1  done with zero mismatches
- sample_count  output  CNT_W  accepted samples
- fail_count  output  CNT_W  accepted samples with out_bit != &in_vec
- covered_count  output  N+1  distinct patterns seen, 0..2**N
- first_fail_vec  output  N  in_vec of the earliest mismatch
- first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Reset: state=IDLE. All outputs 0. Coverage bitmap all 0.
- Handshake:
  - accept = valid & ready.
  - ready = (state==RUN), driven from a register, not combinationally from inputs.
  - valid while ready=0 is ignored; no queueing.
  - Source may hold valid high for back-to-back accepts, one per cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --completing accept--> DONE.
  - DONE --start--> RUN.
  - RUN --start--> RUN (restart).
  - No other transitions.
- start handling:
  - start in any state clears counters, bitmap, first_fail_*, done and pass on the next edge.
  - A valid sample in the same cycle as start is ignored (not accepted).
- Per accepted sample, results appear registered on the next edge (1-cycle latency):
  - sample_count += 1.
  - expected = &in_vec. If out_bit != expected: fail_count += 1.
  - On the first mismatch of a session, capture first_fail_vec=in_vec and set first_fail_valid=1; later mismatches do not overwrite it.
  - If bitmap[in_vec]==0: set it and increment covered_count. Repeated patterns leave coverage unchanged but still count and check.
- Completion:
  - When an accept makes covered_count reach 2**N, the next edge sets state=DONE, done=1, busy=0, ready=0.
  - On that same edge, pass = (fail_count including this sample == 0).
- Counters saturate at 2**CNT_W-1; no wrap.
- busy=1 exactly in RUN. done and pass hold until start or reset.
- X/Z on in_vec or out_bit during an accept is counted as a mismatch.
- Reset asserted mid-session aborts immediately to reset values. No partial results are retained.

Optional Feature:
- Macro GATE_CHK_ABORT_EN.
- Defined: the first mismatch (after the 1-cycle latency) moves RUN->DONE with done=1, pass=0, ready=0; covered_count reflects only patterns accepted before the abort.
- Undefined: mismatches never end a session; only full coverage reaches DONE.

Test Plan:
- N=2, reset, start, then ideal AND responses for in_vec 0,1,2,3 back-to-back -> after the 4th accept plus one cycle: done=1, pass=1, sample_count=4, fail_count=0, covered_count=4.
- Same sequence with out_bit=1 for in_vec=2 -> done=1, pass=0, fail_count=1, first_fail_vec=2'b10, first_fail_valid=1. With GATE_CHK_ABORT_EN: done one cycle after the in_vec=2 accept, covered_count=3.
- Samples 3,3,0,0,1 then 2 -> covered_count sequence 1,1,2,2,3,4; sample_count=6; done only after the 6th accept.
- valid pulses in IDLE and DONE, and valid on the same cycle as start -> sample_count unchanged, ready=0 in IDLE/DONE.
- Assert start mid-RUN after 2 samples (one failing) -> all counters and first_fail_valid=0 next cycle, busy=1; then a full clean sweep gives pass=1.
- CNT_W=2, 5 repeated samples of in_vec=0 with out_bit=1 -> sample_count and fail_count saturate at 3. Drop rst_n mid-session asynchronously -> all outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/gate_response_checker.sv
// gate_response_checker: response end for an N-input AND gate.
// Accepts (in_vec, out_bit) samples over valid/ready, checks each observed
// output against &in_vec, counts samples and mismatches, and tracks which of
// the 2**N input patterns have been seen. done/pass rise once every pattern
// has been covered.
// Optional build macro GATE_CHK_ABORT_EN: when defined, the first mismatch
// ends the session early with done=1, pass=0.
module gate_response_checker #(
  parameter int N     = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     in_vec,
  input  logic             out_bit,
  input  logic             valid,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [N:0]       covered_count,
  output logic [N-1:0]     first_fail_vec,
  output logic             first_fail_valid
);

  localparam int               PATTERNS = 2**N;
  localparam logic [N:0]       COV_FULL = (N+1)'(PATTERNS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [CNT_W-1:0]    sample_q, sample_d;
  logic [CNT_W-1:0]    fail_q, fail_d;
  logic [N:0]          cov_q, cov_d;
  logic [PATTERNS-1:0] bitmap_q, bitmap_d;
  logic [N-1:0]        ffv_q, ffv_d;
  logic                ffvalid_q, ffvalid_d;

  logic expected;
  logic mismatch;
  logic accept;
  logic finish;

  // Next-state logic: start wins over everything, otherwise fold in one accepted sample.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    sample_d  = sample_q;
    fail_d    = fail_q;
    cov_d     = cov_q;
    bitmap_d  = bitmap_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    finish    = 1'b0;

    expected = &in_vec;
    // An unknown on either operand must count as a mismatch, hence the case inequality.
    mismatch = ((out_bit ^ expected) !== 1'b0);
    accept   = valid & (state_q == RUN) & ~start;

    if (start) begin
      state_d   = RUN;
      ready_d   = 1'b1;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      sample_d  = '0;
      fail_d    = '0;
      cov_d     = '0;
      bitmap_d  = '0;
      ffv_d     = '0;
      ffvalid_d = 1'b0;
    end else if (accept) begin
      if (sample_q != CNT_MAX) sample_d = sample_q + CNT_W'(1);
      if (mismatch) begin
        if (fail_q != CNT_MAX) fail_d = fail_q + CNT_W'(1);
        if (!ffvalid_q) begin
          ffv_d     = in_vec;
          ffvalid_d = 1'b1;
        end
      end
      if (!bitmap_q[in_vec]) begin
        bitmap_d[in_vec] = 1'b1;
        cov_d            = cov_q + (N+1)'(1);
      end
`ifdef GATE_CHK_ABORT_EN
      finish = (cov_d == COV_FULL) | mismatch;
`else
      finish = (cov_d == COV_FULL);
`endif
      if (finish) begin
        state_d = DONE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (fail_d == '0);
      end
    end
  end

  // State and result registers; reset drops everything back to an empty IDLE checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      sample_q  <= '0;
      fail_q    <= '0;
      cov_q     <= '0;
      bitmap_q  <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      sample_q  <= sample_d;
      fail_q    <= fail_d;
      cov_q     <= cov_d;
      bitmap_q  <= bitmap_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign ready            = ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign sample_count     = sample_q;
  assign fail_count       = fail_q;
  assign covered_count    = cov_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Testbench for gate_response_checker: directed sequences plus random
// sessions, checked against a session-level reference model. A second
// instance with CNT_W=2 sees the same stimulus to exercise saturation.
module tb_gate_response_checker;

`ifdef GATE_CHK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  in_vec;
  logic        out_bit;
  logic        valid;

  logic        ready, busy, done, pass;
  logic [15:0] sample_count, fail_count;
  logic [2:0]  covered_count;
  logic [1:0]  first_fail_vec;
  logic        first_fail_valid;

  logic        sReady, sBusy, sDone, sPass;
  logic [1:0]  sSample, sFail;
  logic [2:0]  sCovered;
  logic [1:0]  sFfv;
  logic        sFfValid;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: a session is either active or not; results are plain integers.
  bit         mActive, mDone, mPass, mFfValid;
  int         mSample, mFail;
  logic [1:0] mFfv;
  logic [1:0] seen[$];

  gate_response_checker #(.N(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec),
    .out_bit(out_bit), .valid(valid), .ready(ready), .busy(busy),
    .done(done), .pass(pass), .sample_count(sample_count),
    .fail_count(fail_count), .covered_count(covered_count),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );

  gate_response_checker #(.N(2), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec),
    .out_bit(out_bit), .valid(valid), .ready(sReady), .busy(sBusy),
    .done(sDone), .pass(sPass), .sample_count(sSample),
    .fail_count(sFail), .covered_count(sCovered),
    .first_fail_vec(sFfv), .first_fail_valid(sFfValid)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sat(int value, int maxValue);
    return (value > maxValue) ? maxValue : value;
  endfunction

  task automatic modelReset();
    mActive  = 0;
    mDone    = 0;
    mPass    = 0;
    mFfValid = 0;
    mSample  = 0;
    mFail    = 0;
    mFfv     = 2'b00;
    seen.delete();
  endtask

  // One clock edge of the model, given the inputs that were present before the edge.
  task automatic modelEdge(bit s, logic [1:0] v, bit b, bit vld);
    bit isNew;
    bit bad;
    if (s) begin
      modelReset();
      mActive = 1;
    end else if (vld && mActive) begin
      mSample++;
      bad = (b != (v == 2'b11));
      if (bad) begin
        mFail++;
        if (!mFfValid) begin
          mFfValid = 1;
          mFfv     = v;
        end
      end
      isNew = 1;
      foreach (seen[i]) if (seen[i] == v) isNew = 0;
      if (isNew) seen.push_back(v);
      if (seen.size() == 4 || (ABORT && bad)) begin
        mActive = 0;
        mDone   = 1;
        mPass   = (mFail == 0);
      end
    end
  endtask

  task automatic checkVal(string tag, int unsigned observed, int unsigned expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic checkOutput(string tag);
    checkVal({tag, ".ready"},        32'(ready),            32'(mActive));
    checkVal({tag, ".busy"},         32'(busy),             32'(mActive));
    checkVal({tag, ".done"},         32'(done),             32'(mDone));
    checkVal({tag, ".pass"},         32'(pass),             32'(mPass));
    checkVal({tag, ".sample"},       32'(sample_count),     32'(sat(mSample, 65535)));
    checkVal({tag, ".fail"},         32'(fail_count),       32'(sat(mFail, 65535)));
    checkVal({tag, ".covered"},      32'(covered_count),    32'(seen.size()));
    checkVal({tag, ".ffv"},          32'(first_fail_vec),   32'(mFfv));
    checkVal({tag, ".ffvalid"},      32'(first_fail_valid), 32'(mFfValid));
    checkVal({tag, ".sat.sample"},   32'(sSample),          32'(sat(mSample, 3)));
    checkVal({tag, ".sat.fail"},     32'(sFail),            32'(sat(mFail, 3)));
    checkVal({tag, ".sat.done"},     32'(sDone),            32'(mDone));
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, sample #1 later.
  task automatic applyStimulus(bit s, logic [1:0] v, bit b, bit vld);
    start   = s;
    in_vec  = v;
    out_bit = b;
    valid   = vld;
    @(posedge clk);
    #1;
    modelEdge(s, v, b, vld);
  endtask

  task automatic sweep(string tag, logic [1:0] badVec, bit injectBad);
    logic [1:0] v;
    bit b;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      b = (v == 2'b11);
      if (injectBad && v == badVec) b = ~b;
      applyStimulus(0, v, b, 1);
      checkOutput($sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    logic [1:0] seq[6];
    logic [1:0] rv;
    bit         rb;
    bit         rvalid;

    rst_n   = 1'b0;
    start   = 1'b0;
    in_vec  = 2'b00;
    out_bit = 1'b0;
    valid   = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst_n = 1'b1;

    applyStimulus(0, 2'b11, 1, 1);
    checkOutput("idleValid");
    applyStimulus(1, 2'b11, 1, 1);
    checkOutput("startWithValid");

    sweep("clean", 2'b00, 0);
    applyStimulus(0, 2'b00, 0, 0);
    checkOutput("cleanHold");
    applyStimulus(0, 2'b01, 0, 1);
    checkOutput("doneValid");

    applyStimulus(1, 2'b00, 0, 0);
    checkOutput("start2");
    sweep("bad2", 2'b10, 1);
    applyStimulus(0, 2'b00, 0, 0);
    checkOutput("bad2Hold");

    applyStimulus(1, 2'b00, 0, 0);
    checkOutput("start3");
    seq = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, seq[i], seq[i] == 2'b11, 1);
      checkOutput($sformatf("repeat[%0d]", i));
    end

    applyStimulus(1, 2'b00, 0, 0);
    checkOutput("start4");
    applyStimulus(0, 2'b00, 1, 1);
    checkOutput("pre0");
    applyStimulus(0, 2'b01, 0, 1);
    checkOutput("pre1");
    applyStimulus(1, 2'b10, 0, 1);
    checkOutput("restart");
    sweep("afterRestart", 2'b00, 0);

    for (int s = 0; s < 4; s++) begin
      applyStimulus(1, 2'b00, 0, 0);
      checkOutput($sformatf("rndStart[%0d]", s));
      for (int c = 0; c < 16; c++) begin
        rv     = 2'($urandom_range(0, 3));
        rb     = (rv == 2'b11);
        if ($urandom_range(0, 7) == 0) rb = ~rb;
        rvalid = ($urandom_range(0, 3) != 0);
        applyStimulus(0, rv, rb, rvalid);
        checkOutput($sformatf("rnd[%0d][%0d]", s, c));
      end
    end

    applyStimulus(1, 2'b00, 0, 0);
    checkOutput("satStart");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 2'b00, 1, 1);
      checkOutput($sformatf("sat[%0d]", i));
    end

    applyStimulus(1, 2'b00, 0, 0);
    applyStimulus(0, 2'b00, 0, 1);
    applyStimulus(0, 2'b01, 0, 1);
    checkOutput("preAsync");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncReset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 0, 0);
    checkOutput("afterAsync");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
